// File: rtl/timer_key_entry.sv
// Keypad entry stage for the BCD timer: shifts digits into M:S:S and sequences load/start.
// Optional quick-start (0:30 on a bare start key) is compiled in with TIMER_QUICK_START_EN.
module timer_key_entry #(
    parameter logic [3:0] KEY_START  = 4'hA,
    parameter logic [3:0] KEY_CANCEL = 4'hB
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       busy,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       load,
    output logic       start,
    output logic       stop,
    output logic       err,
    output logic [1:0] digit_count,
    output logic       entry_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_LOAD  = 2'd2,
        S_START = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic [1:0] cnt_q, cnt_d;
    logic       load_q, load_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       err_q, err_d;
    logic       entry_q, entry_d;

    logic       is_digit;
    logic       is_start;
    logic       is_cancel;
    logic       start_bad;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_start  = key_valid && (key_code == KEY_START);
    assign is_cancel = key_valid && (key_code == KEY_CANCEL);
    // Tens of seconds above 5 or an all-zero time cannot be loaded.
    assign start_bad = (tens_q > 4'd5) || ({min_q, tens_q, units_q} == 12'd0);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        cnt_d   = cnt_q;
        load_d  = 1'b1;
        start_d = 1'b0;
        stop_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_digit && !busy) begin
                    units_d = key_code;
                    cnt_d   = 2'd1;
                    state_d = S_ENTRY;
                end else if (is_cancel && busy) begin
                    stop_d = 1'b1;
`ifdef TIMER_QUICK_START_EN
                end else if (is_start && !busy && (cnt_q == 2'd0)) begin
                    min_d   = 4'd0;
                    tens_d  = 4'd3;
                    units_d = 4'd0;
                    load_d  = 1'b0;
                    state_d = S_LOAD;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ENTRY: begin
                if (is_digit) begin
                    if (cnt_q != 2'd3) begin
                        min_d   = tens_q;
                        tens_d  = units_q;
                        units_d = key_code;
                        cnt_d   = cnt_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (is_start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        load_d  = 1'b0;
                        state_d = S_LOAD;
                    end
                end else if (is_cancel) begin
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ENTRY;
                end
            end
            S_LOAD: begin
                start_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                min_d   = 4'd0;
                tens_d  = 4'd0;
                units_d = 4'd0;
                cnt_d   = 2'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        entry_d = (state_d == S_ENTRY);
    end

    // State and registered outputs, with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            cnt_q   <= 2'd0;
            load_q  <= 1'b1;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            entry_q <= entry_d;
        end
    end

    assign min_digit    = min_q;
    assign sec_tens     = tens_q;
    assign sec_units    = units_q;
    assign load         = load_q;
    assign start        = start_q;
    assign stop         = stop_q;
    assign err          = err_q;
    assign digit_count  = cnt_q;
    assign entry_active = entry_q;

endmodule
